// File: rtl/control_step_sequencer.sv
// control_step_sequencer
//   Hardwired control-step generator for the single-bus datapath. It fetches an
//   instruction (PC->MAR, memory->MDR, MDR->IR). It then decodes IR and runs the
//   execute steps for register ALU and unary instructions. One instance per CPU.
//
// Optional feature: define SEQ_MEM_WAIT_EN to make T1 wait for mem_ready. The wait
//   is bounded by WAIT_MAX cycles. If it expires, the sticky mem_timeout flag is set.
//   Without the macro, T1 always lasts one cycle and mem_timeout is tied low.
//
// Ports
//   clk          in   rising-edge clock
//   clr          in   asynchronous reset, active-high
//   run          in   keep fetching/executing (sampled in IDLE and at instruction end)
//   mem_ready    in   memory data valid (SEQ_MEM_WAIT_EN only)
//   ir_in        in   IR contents, valid from T3 onward
//   enable       out  one-hot load enables: Rn=n, PC=20, MDR=21, Y=22, IR=23, Z=24, MAR=25
//   busSelect    out  bus source code: Rn=n, PC=20, MDR=21, Zlow=24; 0 when idle
//   alu_op       out  ALU operation (IR opcode) in the step that loads Z
//   MR_Read      out  memory read strobe into the MDR mux
//   pc_inc       out  PC increment
//   done         out  one-cycle pulse on the last step of every instruction
//   illegal      out  one-cycle pulse in T3 when the instruction is not supported
//   mem_timeout  out  sticky memory-wait timeout flag
//   step         out  current state code, for debug
module control_step_sequencer #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned EN_W     = 32,
  parameter int unsigned BSEL_W   = 5,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [31:0]       ir_in,
  output logic [EN_W-1:0]   enable,
  output logic [BSEL_W-1:0] busSelect,
  output logic [4:0]        alu_op,
  output logic              MR_Read,
  output logic              pc_inc,
  output logic              done,
  output logic              illegal,
  output logic              mem_timeout,
  output logic [3:0]        step
);

  // Fixed enable slots and bus source codes.
  localparam int unsigned SlotPc   = 20;
  localparam int unsigned SlotMdr  = 21;
  localparam int unsigned SlotY    = 22;
  localparam int unsigned SlotIr   = 23;
  localparam int unsigned SlotZ    = 24;
  localparam int unsigned SlotMar  = 25;
  localparam int unsigned SelZlow  = 24;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6
  } state_e;

  state_e     state_q;
  logic [4:0] op_q;
  logic [3:0] ra_q;
  logic [3:0] rc_q;

  // IR field decode. IR is loaded at the end of T2, so ir_in is only meaningful
  // in T3. The fields needed later are captured when T3 is left.
  logic [4:0] ir_op;
  logic [3:0] ir_ra;
  logic [3:0] ir_rb;
  logic [3:0] ir_rc;
  logic       is_alu_rr;
  logic       is_unary;
  logic       ra_ok;
  logic       rb_ok;
  logic       rc_ok;
  logic       ir_illegal;

  assign ir_op = ir_in[31:27];
  assign ir_ra = ir_in[26:23];
  assign ir_rb = ir_in[22:19];
  assign ir_rc = ir_in[18:15];

  assign is_alu_rr = (ir_op >= 5'd3) && (ir_op <= 5'd15);
  assign is_unary  = (ir_op == 5'd16) || (ir_op == 5'd18);
  assign ra_ok     = 32'(ir_ra) < NUM_REGS;
  assign rb_ok     = 32'(ir_rb) < NUM_REGS;
  assign rc_ok     = 32'(ir_rc) < NUM_REGS;

  // Only the register fields the class actually uses are range-checked.
  assign ir_illegal = !((is_alu_rr && ra_ok && rb_ok && rc_ok) ||
                        (is_unary && ra_ok && rb_ok));

`ifdef SEQ_MEM_WAIT_EN
  localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [WaitW-1:0] wait_q;
  logic             timeout_q;

  assign mem_timeout = timeout_q;

  logic unused_ir;
  assign unused_ir = ^ir_in[14:0];
`else
  assign mem_timeout = 1'b0;

  logic unused_in;
  assign unused_in = ^{mem_ready, ir_in[14:0]};
`endif

  // State register plus the operands captured at the end of T3.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      op_q      <= '0;
      ra_q      <= '0;
      rc_q      <= '0;
`ifdef SEQ_MEM_WAIT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StT0;
        end
        StT0: state_q <= StT1;
        StT1: begin
`ifdef SEQ_MEM_WAIT_EN
          if (mem_ready) begin
            wait_q  <= '0;
            state_q <= StT2;
          end else if (32'(wait_q) == WAIT_MAX - 1) begin
            // This was the WAIT_MAX-th cycle without data, so give up.
            wait_q    <= '0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`else
          state_q <= StT2;
`endif
        end
        StT2: state_q <= StT3;
        StT3: begin
          op_q <= ir_op;
          ra_q <= ir_ra;
          rc_q <= ir_rc;
          if (ir_illegal) begin
            state_q <= run ? StT0 : StIdle;
          end else if (is_unary) begin
            state_q <= StT5;
          end else begin
            state_q <= StT4;
          end
        end
        StT4: state_q <= StT5;
        StT5: state_q <= run ? StT0 : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore output decode. T3 also looks at ir_in, which is the IR register output.
  always_comb begin
    enable    = '0;
    busSelect = '0;
    alu_op    = '0;
    MR_Read   = 1'b0;
    pc_inc    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StT0: begin
        busSelect        = BSEL_W'(SlotPc);
        enable[SlotMar]  = 1'b1;
        pc_inc           = 1'b1;
      end
      StT1: begin
        MR_Read          = 1'b1;
        enable[SlotMdr]  = 1'b1;
      end
      StT2: begin
        busSelect        = BSEL_W'(SlotMdr);
        enable[SlotIr]   = 1'b1;
      end
      StT3: begin
        if (ir_illegal) begin
          illegal = 1'b1;
          done    = 1'b1;
        end else if (is_unary) begin
          busSelect      = BSEL_W'(ir_rb);
          enable[SlotZ]  = 1'b1;
          alu_op         = ir_op;
        end else begin
          busSelect      = BSEL_W'(ir_rb);
          enable[SlotY]  = 1'b1;
        end
      end
      StT4: begin
        busSelect        = BSEL_W'(rc_q);
        enable[SlotZ]    = 1'b1;
        alu_op           = op_q;
      end
      StT5: begin
        busSelect        = BSEL_W'(SelZlow);
        enable           = EN_W'(1) << ra_q;
        done             = 1'b1;
      end
      default: ;
    endcase
  end

  assign step = state_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
`timescale 1ns/1ps
module tb_control_step_sequencer;

  localparam int NR   = 12;
  localparam int WMAX = 15;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir_in;
  logic [31:0] enable;
  logic [4:0]  busSelect;
  logic [4:0]  alu_op;
  logic        MR_Read;
  logic        pc_inc;
  logic        done;
  logic        illegal;
  logic        mem_timeout;
  logic [3:0]  step;

  int   errors = 0;
  int   checks = 0;
  logic exp_mt = 1'b0;

  always #5 clk = ~clk;

  control_step_sequencer #(
    .NUM_REGS(NR),
    .EN_W(32),
    .BSEL_W(5),
    .WAIT_MAX(WMAX)
  ) dut (
    .clk(clk),
    .clr(clr),
    .run(run),
    .mem_ready(mem_ready),
    .ir_in(ir_in),
    .enable(enable),
    .busSelect(busSelect),
    .alu_op(alu_op),
    .MR_Read(MR_Read),
    .pc_inc(pc_inc),
    .done(done),
    .illegal(illegal),
    .mem_timeout(mem_timeout),
    .step(step)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] en;
    logic [4:0]  bs;
    logic [4:0]  op;
    logic        mr;
    logic        inc;
    logic        dn;
    logic        ill;
    logic        mt;
  } obs_t;

  function automatic obs_t cur();
    obs_t o;
    o.st = step; o.en = enable; o.bs = busSelect; o.op = alu_op;
    o.mr = MR_Read; o.inc = pc_inc; o.dn = done; o.ill = illegal; o.mt = mem_timeout;
    return o;
  endfunction

  // Reference model: instruction class, length and per-cycle outputs.
  // Class 0 = illegal, 1 = register ALU, 2 = unary.
  function automatic int cls_of(input logic [31:0] ir);
    int op = int'(ir[31:27]);
    int ra = int'(ir[26:23]);
    int rb = int'(ir[22:19]);
    int rc = int'(ir[18:15]);
    if (op >= 3 && op <= 15) return (ra < NR && rb < NR && rc < NR) ? 1 : 0;
    if (op == 16 || op == 18) return (ra < NR && rb < NR) ? 2 : 0;
    return 0;
  endfunction

  function automatic int len_of(input logic [31:0] ir);
    int c = cls_of(ir);
    return (c == 1) ? 6 : (c == 2) ? 5 : 4;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.mt = exp_mt;
    return o;
  endfunction

  function automatic obs_t exp_at(input logic [31:0] ir, input int k);
    obs_t o = '0;
    int c = cls_of(ir);
    o.mt = exp_mt;
    if (k == 0) begin
      o.st = 4'd1; o.bs = 5'd20; o.en = 32'd1 << 25; o.inc = 1'b1;
    end else if (k == 1) begin
      o.st = 4'd2; o.mr = 1'b1; o.en = 32'd1 << 21;
    end else if (k == 2) begin
      o.st = 4'd3; o.bs = 5'd21; o.en = 32'd1 << 23;
    end else if (k == 3) begin
      o.st = 4'd4;
      if (c == 0) begin
        o.ill = 1'b1; o.dn = 1'b1;
      end else begin
        o.bs = {1'b0, ir[22:19]};
        o.en = (c == 1) ? (32'd1 << 22) : (32'd1 << 24);
        if (c == 2) o.op = ir[31:27];
      end
    end else if (k == len_of(ir) - 1) begin
      o.st = 4'd6; o.bs = 5'd24; o.en = 32'd1 << ir[26:23]; o.dn = 1'b1;
    end else begin
      o.st = 4'd5; o.bs = {1'b0, ir[18:15]}; o.en = 32'd1 << 24; o.op = ir[31:27];
    end
    return o;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r = $urandom;
    int pick = $urandom_range(0, 3);
    if (pick == 1 || pick == 3) r[31:27] = 5'($urandom_range(3, 15));
    else if (pick == 2) r[31:27] = ($urandom_range(0, 1) == 1) ? 5'd16 : 5'd18;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    clr = 1'b1; run = 1'b1; mem_ready = 1'b1; ir_in = 32'h19918000;
    repeat (2) @(posedge clk);
    #1;
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", got, idle_obs());
    end
    run = 1'b0; clr = 1'b0;
    tick(); tick();
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", got, idle_obs());
    end
  endtask

  task automatic test_alu_rr();
    logic [31:0] ir = 32'h19918000;
    obs_t got, exp;
    ir_in = ir; run = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      got = cur(); exp = exp_at(ir, k); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL alu_rr k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 5) begin
        checks++;
        if (enable !== 32'h8) begin
          errors++; $display("FAIL alu_rr_t5_en got=%h exp=%h", enable, 32'h8);
        end
        run = 1'b0;
      end
      tick();
    end
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL alu_rr_idle got=%h exp=%h", got, idle_obs());
    end
  endtask

  task automatic test_unary();
    logic [31:0] ir = 32'h90080000;
    obs_t got, exp;
    ir_in = ir; run = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      got = cur(); exp = exp_at(ir, k); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL unary k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 4) run = 1'b0;
      tick();
    end
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL unary_idle got=%h exp=%h", got, idle_obs());
    end
  endtask

  task automatic test_illegal();
    logic [31:0] irs [3];
    obs_t got, exp;
    irs[0] = {5'd31, 27'h2a5c3e1};
    irs[1] = {5'd5, 4'd2, 4'd3, 4'd13, 15'h0};   // Rc out of range
    irs[2] = {5'd16, 4'd1, 4'd14, 4'd0, 15'h0};  // Rb out of range
    for (int i = 0; i < 3; i++) begin
      ir_in = irs[i]; run = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
        got = cur(); exp = exp_at(irs[i], k); checks++;
        if (got !== exp) begin
          errors++; $display("FAIL illegal%0d k=%0d got=%h exp=%h", i, k, got, exp);
        end
        tick();
      end
      // run still high: the next fetch starts immediately.
      got = cur(); exp = exp_at(irs[i], 0); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL illegal%0d_next got=%h exp=%h", i, got, exp);
      end
      run = 1'b0;
      for (int k = 1; k < 4; k++) tick();
      tick();
      got = cur(); checks++;
      if (got !== idle_obs()) begin
        errors++; $display("FAIL illegal%0d_idle got=%h exp=%h", i, got, idle_obs());
      end
    end
  endtask

  task automatic test_run_drop();
    logic [31:0] ir = {5'd7, 4'd9, 4'd4, 4'd11, 15'h1234};
    obs_t got, exp;
    ir_in = ir; run = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      got = cur(); exp = exp_at(ir, k); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL run_drop k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 3) run = 1'b0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      got = cur(); checks++;
      if (got !== idle_obs()) begin
        errors++; $display("FAIL run_drop_idle%0d got=%h exp=%h", i, got, idle_obs());
      end
      tick();
    end
  endtask

  task automatic test_clr_mid();
    logic [31:0] ir = {5'd4, 4'd5, 4'd6, 4'd7, 15'h0};
    obs_t got, exp;
    ir_in = ir; run = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      got = cur(); exp = exp_at(ir, k); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clr_mid k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k < 4) tick();
    end
    #2 clr = 1'b1;
    #1;
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL clr_async got=%h exp=%h", got, idle_obs());
    end
    tick();
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL clr_held got=%h exp=%h", got, idle_obs());
    end
    clr = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      got = cur(); exp = exp_at(ir, k); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clr_resume k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 5) run = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ir;
    obs_t got, exp;
    ir = rand_ir();
    ir_in = ir; run = 1'b1;
    tick();
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < len_of(ir); k++) begin
        got = cur(); exp = exp_at(ir, k); checks++;
        if (got !== exp) begin
          errors++; $display("FAIL b2b n=%0d ir=%h k=%0d got=%h exp=%h", n, ir, k, got, exp);
        end
        // run is a don't-care mid-instruction; only the final value matters.
        run = ($urandom_range(0, 3) != 0);
        tick();
      end
      if (!run) begin
        got = cur(); checks++;
        if (got !== idle_obs()) begin
          errors++; $display("FAIL b2b_idle n=%0d got=%h exp=%h", n, got, idle_obs());
        end
        run = 1'b1;
        ir = rand_ir();
        ir_in = ir;
        tick();
      end else begin
        ir = rand_ir();
        ir_in = ir;
      end
    end
    run = 1'b0;
    for (int k = 1; k < len_of(ir); k++) tick();
    tick();
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL b2b_end got=%h exp=%h", got, idle_obs());
    end
  endtask

`ifdef SEQ_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [31:0] ir = 32'h19918000;
    obs_t got, exp;
    ir_in = ir; run = 1'b1; mem_ready = 1'b1;
    tick();
    got = cur(); exp = exp_at(ir, 0); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL wait_t0 got=%h exp=%h", got, exp);
    end
    mem_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      got = cur(); exp = exp_at(ir, 1); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wait_t1 c=%0d got=%h exp=%h", c, got, exp);
      end
      mem_ready = (c == 3);
      tick();
    end
    for (int k = 2; k < 6; k++) begin
      got = cur(); exp = exp_at(ir, k); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wait_rest k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 5) run = 1'b0;
      tick();
    end
    // Timeout: mem_ready never arrives.
    run = 1'b1; mem_ready = 1'b0;
    tick();
    run = 1'b0;
    tick();
    for (int c = 0; c < WMAX; c++) begin
      got = cur(); exp = exp_at(ir, 1); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL timeout_t1 c=%0d got=%h exp=%h", c, got, exp);
      end
      tick();
    end
    exp_mt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      got = cur(); checks++;
      if (got !== idle_obs()) begin
        errors++; $display("FAIL timeout_idle%0d got=%h exp=%h", i, got, idle_obs());
      end
      tick();
    end
    clr = 1'b1;
    #1;
    exp_mt = 1'b0;
    got = cur(); checks++;
    if (got !== idle_obs()) begin
      errors++; $display("FAIL timeout_clr got=%h exp=%h", got, idle_obs());
    end
    clr = 1'b0; mem_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_rr();
    test_unary();
    test_illegal();
    test_run_drop();
    test_clr_mid();
    test_back_to_back();
`ifdef SEQ_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
